// File: rtl/circuito_pwm_multicanal.sv
// ============================================================================
// circuito_pwm_multicanal
//
// N-channel PWM generator for servo/actuator drive. All channels share one
// period counter. Each channel has a pending width, written at any time over a
// simple write port, and an active width used to generate the output. Pending
// widths and the enable vector are copied to the active set only on the last
// count of a period, so an output never changes shape mid-period.
//
// Optional feature (macro PWM_RAMPA_EN):
//   When defined, at each period boundary the active width moves toward the
//   pending width by at most PASSO_RAMPA clocks instead of jumping to it.
//   When undefined, the active width takes the pending width directly and
//   PASSO_RAMPA has no effect.
//
// Parameters:
//   N_CANAIS      number of PWM channels (1..16)
//   LARGURA_CONT  counter/width bit width, 2**LARGURA_CONT > PERIODO
//   PERIODO       period length in clocks
//   PASSO_RAMPA   max width change per period (ramp build only)
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous reset, active low
//   wr_en        in   write strobe (one write per cycle)
//   wr_canal     in   target channel; codes >= N_CANAIS are ignored
//   wr_largura   in   requested pulse width in clocks (saturates at PERIODO)
//   habilita     in   per-channel enable, sampled at the period boundary
//   pwm          out  registered PWM outputs
//   fim_periodo  out  one-cycle pulse, high while pwm shows count 0
// ============================================================================
module circuito_pwm_multicanal #(
    parameter  int N_CANAIS     = 4,
    parameter  int LARGURA_CONT = 20,
    parameter  int PERIODO      = 1000000,
    parameter  int PASSO_RAMPA  = 500,
    localparam int W_CANAL      = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [W_CANAL-1:0]      wr_canal,
    input  logic [LARGURA_CONT-1:0] wr_largura,
    input  logic [N_CANAIS-1:0]     habilita,
    output logic [N_CANAIS-1:0]     pwm,
    output logic                    fim_periodo
);

    localparam logic [LARGURA_CONT-1:0] PERIODO_W = LARGURA_CONT'(PERIODO);
    localparam logic [LARGURA_CONT-1:0] ULTIMO_W  = LARGURA_CONT'(PERIODO - 1);

    logic [LARGURA_CONT-1:0] contagem_reg;
    logic [LARGURA_CONT-1:0] contagem_next;
    logic [N_CANAIS-1:0]     hab_ativo_reg;
    logic [N_CANAIS-1:0]     pwm_reg;
    logic [N_CANAIS-1:0]     pwm_next;
    logic                    bnd_reg;
    logic                    fim_periodo_reg;
    logic                    bnd;
    logic [LARGURA_CONT-1:0] largura_sat;

    // Last count of the period: the only cycle where active state is updated.
    assign bnd           = (contagem_reg == ULTIMO_W);
    assign contagem_next = bnd ? '0 : contagem_reg + LARGURA_CONT'(1);

    // Widths above one full period would mean "always high" anyway; clamp so
    // the stored value stays meaningful for the ramp arithmetic.
    assign largura_sat = (wr_largura > PERIODO_W) ? PERIODO_W : wr_largura;

    genvar gi;
    generate
        for (gi = 0; gi < N_CANAIS; gi++) begin : g_canal
            logic [LARGURA_CONT-1:0] pendente_reg;
            logic [LARGURA_CONT-1:0] ativo_reg;
            logic [LARGURA_CONT-1:0] ativo_next;
            logic                    wr_sel;

            // Each channel decodes only its own index, so out-of-range
            // channel codes select nothing and leave all state untouched.
            assign wr_sel = wr_en && (wr_canal == W_CANAL'(gi));

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    pendente_reg <= '0;
                    ativo_reg    <= '0;
                end else begin
                    // A write landing on the boundary cycle reaches
                    // pendente_reg only after ativo_reg has sampled the old
                    // value, so it is deferred to the next boundary.
                    if (wr_sel) begin
                        pendente_reg <= largura_sat;
                    end
                    if (bnd) begin
                        ativo_reg <= ativo_next;
                    end
                end
            end

`ifdef PWM_RAMPA_EN
            localparam logic [LARGURA_CONT-1:0] PASSO_W = LARGURA_CONT'(PASSO_RAMPA);

            // Step by PASSO_RAMPA only when the remaining distance exceeds it;
            // this keeps both directions free of wrap-around.
            always_comb begin
                ativo_next = ativo_reg;
                if (pendente_reg > ativo_reg) begin
                    if (32'(pendente_reg - ativo_reg) > PASSO_RAMPA) begin
                        ativo_next = ativo_reg + PASSO_W;
                    end else begin
                        ativo_next = pendente_reg;
                    end
                end else if (pendente_reg < ativo_reg) begin
                    if (32'(ativo_reg - pendente_reg) > PASSO_RAMPA) begin
                        ativo_next = ativo_reg - PASSO_W;
                    end else begin
                        ativo_next = pendente_reg;
                    end
                end
            end
`else
            assign ativo_next = pendente_reg;
`endif

            // Width PERIODO makes the compare true for every count, so the
            // output stays high across the wrap with no low cycle.
            assign pwm_next[gi] = hab_ativo_reg[gi] & (contagem_reg < ativo_reg);
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            contagem_reg    <= '0;
            hab_ativo_reg   <= '0;
            bnd_reg         <= 1'b0;
            fim_periodo_reg <= 1'b0;
            pwm_reg         <= '0;
        end else begin
            contagem_reg <= contagem_next;
            if (bnd) begin
                hab_ativo_reg <= habilita;
            end
            // The boundary marker goes through two stages so that it lines
            // up with the registered pwm showing count 0 of the new period.
            bnd_reg         <= bnd;
            fim_periodo_reg <= bnd_reg;
            pwm_reg         <= pwm_next;
        end
    end

    assign pwm         = pwm_reg;
    assign fim_periodo = fim_periodo_reg;

endmodule

// File: tb/tb_circuito_pwm_multicanal.sv
// ============================================================================
// tb_circuito_pwm_multicanal
//
// Directed bench: N_CANAIS=2, LARGURA_CONT=6, PERIODO=20, PASSO_RAMPA=3.
// A second instance with three channels (two-bit channel code) receives the
// same traffic plus a write to the unused code 3, which must change nothing.
// Each period is captured sample by sample on the falling edge, starting at
// the fim_periodo sample, and compared against hand-written pulse shapes.
// ============================================================================
module tb_circuito_pwm_multicanal;

    logic       clock      = 1'b0;
    logic       reset_n    = 1'b0;
    logic       wr_en      = 1'b0;
    logic [0:0] wr_canal   = 1'b0;
    logic [5:0] wr_largura = 6'd0;
    logic [1:0] habilita   = 2'b00;
    logic [1:0] pwm;
    logic       fim_periodo;

    logic       wr_en3     = 1'b0;
    logic [1:0] wr_canal3  = 2'd0;
    logic [2:0] hab3;
    logic [2:0] pwm3;
    logic       fim3;

    int total = 0;
    int bad   = 0;

    // Pending actions applied at given sample indices of the next period.
    int         sk [4];
    int         sch[4];
    int         sw [4];
    bit         s3only[4];
    int         sn     = 0;
    int         hab_k  = -1;
    logic [1:0] hab_val = 2'b00;
    logic [1:0] exp_pre;

    assign hab3 = {1'b0, habilita};

    always #5 clock = ~clock;

    circuito_pwm_multicanal #(
        .N_CANAIS(2), .LARGURA_CONT(6), .PERIODO(20), .PASSO_RAMPA(3)
    ) dut (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_canal(wr_canal),
        .wr_largura(wr_largura), .habilita(habilita), .pwm(pwm),
        .fim_periodo(fim_periodo)
    );

    circuito_pwm_multicanal #(
        .N_CANAIS(3), .LARGURA_CONT(6), .PERIODO(20), .PASSO_RAMPA(3)
    ) dut3 (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en3), .wr_canal(wr_canal3),
        .wr_largura(wr_largura), .habilita(hab3), .pwm(pwm3),
        .fim_periodo(fim3)
    );

    function automatic logic [19:0] pat(input int w);
        logic [19:0] r;
        r = '0;
        for (int k = 0; k < 20; k++) begin
            if (k < w) r[k] = 1'b1;
        end
        return r;
    endfunction

    task automatic sched_wr(input int k, input int ch, input int w, input bit only3);
        sk[sn] = k; sch[sn] = ch; sw[sn] = w; s3only[sn] = only3;
        sn++;
    endtask

    task automatic sched_hab(input int k, input logic [1:0] v);
        hab_k   = k;
        hab_val = v;
    endtask

    // Captures one full period starting at the fim_periodo sample and applies
    // any scheduled writes/enable changes at their sample index.
    task automatic check_period(input logic [19:0] e0, input logic [19:0] e1, input string tag);
        int          n;
        logic [19:0] o0, o1, of, o30, o31, o32;
        n = 0;
        while (fim_periodo !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        total++;
        assert (fim_periodo === 1'b1) else begin
            bad++;
            $error("FAIL %s_sync observed=%b expected=1", tag, fim_periodo);
        end
        for (int k = 0; k < 20; k++) begin
            o0[k]  = pwm[0];
            o1[k]  = pwm[1];
            of[k]  = fim_periodo;
            o30[k] = pwm3[0];
            o31[k] = pwm3[1];
            o32[k] = pwm3[2];
            wr_en  = 1'b0;
            wr_en3 = 1'b0;
            for (int s = 0; s < sn; s++) begin
                if (sk[s] == k) begin
                    wr_largura = 6'(sw[s]);
                    wr_canal3  = 2'(sch[s]);
                    wr_en3     = 1'b1;
                    if (!s3only[s]) begin
                        wr_en    = 1'b1;
                        wr_canal = 1'(sch[s]);
                    end
                end
            end
            if (hab_k == k) habilita = hab_val;
            @(negedge clock);
        end
        wr_en  = 1'b0;
        wr_en3 = 1'b0;
        sn     = 0;
        hab_k  = -1;
        total++;
        assert (o0 === e0) else begin
            bad++;
            $error("FAIL %s_ch0 observed=%b expected=%b", tag, o0, e0);
        end
        total++;
        assert (o1 === e1) else begin
            bad++;
            $error("FAIL %s_ch1 observed=%b expected=%b", tag, o1, e1);
        end
        total++;
        assert ({o32, o31, o30} === {20'h0, e1, e0}) else begin
            bad++;
            $error("FAIL %s_dut3 observed=%h expected=%h", tag, {o32, o31, o30}, {20'h0, e1, e0});
        end
        total++;
        assert (of === 20'h00001) else begin
            bad++;
            $error("FAIL %s_fim observed=%b expected=%b", tag, of, 20'h00001);
        end
        total++;
        assert (fim_periodo === 1'b1) else begin
            bad++;
            $error("FAIL %s_spacing observed=%b expected=1", tag, fim_periodo);
        end
        $display("period %s: ch0=%b ch1=%b", tag, o0, o1);
    endtask

    initial begin
        // Step 1: reset held for three periods, outputs quiet.
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (i == 5 || i == 30 || i == 59) begin
                total++;
                assert ({pwm, fim_periodo, pwm3} === 6'b0) else begin
                    bad++;
                    $error("FAIL reset_hold observed=%b expected=%b", {pwm, fim_periodo, pwm3}, 6'b0);
                end
            end
        end
        reset_n = 1'b1;
        check_period(20'h0, 20'h0, "idle_a");

`ifdef PWM_RAMPA_EN
        sched_wr(3, 0, 5, 1'b0);
        sched_hab(3, 2'b01);
        check_period(20'h0, 20'h0, "idle_b");
        check_period(pat(3), 20'h0, "ramp_up3");
        sched_wr(3, 0, 15, 1'b0);
        check_period(pat(5), 20'h0, "ramp_up5");
        check_period(pat(8), 20'h0, "ramp_8");
        sched_wr(10, 3, 9, 1'b1);
        check_period(pat(11), 20'h0, "ramp_11");
        check_period(pat(14), 20'h0, "ramp_14");
        sched_wr(3, 0, 2, 1'b0);
        check_period(pat(15), 20'h0, "ramp_15");
        check_period(pat(12), 20'h0, "ramp_dn12");
        exp_pre = 2'b01;
`else
        // Step 2: channel 0 width 5, enable channel 0.
        sched_wr(3, 0, 5, 1'b0);
        sched_hab(3, 2'b01);
        check_period(20'h0, 20'h0, "idle_b");
        // Step 3: channel 1 width 25 clamps to a full period.
        sched_wr(3, 1, 25, 1'b0);
        sched_hab(3, 2'b11);
        check_period(pat(5), 20'h0, "w5");
        // Step 4: mid-period write of 8, boundary-cycle write of 12.
        sched_wr(5, 0, 8, 1'b0);
        sched_wr(18, 0, 12, 1'b0);
        check_period(pat(5), 20'hFFFFF, "sat20");
        check_period(pat(8), 20'hFFFFF, "w8");
        // Step 5: invalid channel write on dut3, drop enable 0 mid-pulse.
        sched_wr(10, 3, 9, 1'b1);
        sched_hab(4, 2'b10);
        check_period(pat(12), 20'hFFFFF, "w12");
        sched_hab(2, 2'b11);
        sched_wr(3, 0, 0, 1'b0);
        check_period(20'h0, 20'hFFFFF, "dis0");
        sched_wr(7, 1, 19, 1'b0);
        check_period(20'h0, 20'hFFFFF, "w0");
        check_period(20'h0, pat(19), "w19");
        exp_pre = 2'b10;
`endif

        // Step 6: reset asserted in the middle of a pulse.
        for (int n = 0; n < 40 && fim_periodo !== 1'b1; n++) @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        total++;
        assert (pwm === exp_pre) else begin
            bad++;
            $error("FAIL pre_reset observed=%b expected=%b", pwm, exp_pre);
        end
        reset_n = 1'b0;
        #1;
        total++;
        assert ({pwm, fim_periodo, pwm3} === 6'b0) else begin
            bad++;
            $error("FAIL async_reset observed=%b expected=%b", {pwm, fim_periodo, pwm3}, 6'b0);
        end
        for (int i = 0; i < 5; i++) @(negedge clock);
        reset_n = 1'b1;
        check_period(20'h0, 20'h0, "post_rst_a");
        check_period(20'h0, 20'h0, "post_rst_b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
